// File: rtl/beam_thresh_loader.sv
// Shadow threshold table (2 types x NBEAMS) streamed into the beamformer
// cascade chain on request, followed by a single commit pulse per type.
module beam_thresh_loader #(
  parameter int                     NBEAMS         = 48,
  parameter int                     THRESH_BITS    = 18,
  parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000,
  parameter int                     ADDR_BITS      = $clog2(NBEAMS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_BITS-1:0]     thr_addr_i,
  input  logic                     thr_sel_i,
  input  logic [THRESH_BITS-1:0]   thr_dat_i,
  input  logic                     thr_we_i,
  input  logic [1:0]               load_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2*THRESH_BITS-1:0] thresh_o,
  output logic [1:0]               thresh_wr_o,
  output logic [1:0]               thresh_update_o
);

  typedef enum logic [2:0] {IDLE, PRIME, SHIFT, UPDATE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           mask, mask_nxt, pend, pend_nxt;
  logic [ADDR_BITS-1:0] cnt, cnt_nxt, rd_addr;

  logic                     busy_nxt, done_nxt;
  logic [1:0]               wr_nxt, upd_nxt;
  logic [2*THRESH_BITS-1:0] thresh_nxt;

  // Power-up content only; reset deliberately leaves the table alone.
  logic [1:0][THRESH_BITS-1:0] tbl [NBEAMS] = '{default: {2{DEFAULT_THRESH}}};

  always_ff @(posedge clk_i) begin
    if (thr_we_i && (int'(thr_addr_i) < NBEAMS))
      tbl[thr_addr_i][thr_sel_i] <= thr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      mask  <= '0;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      pend  <= pend_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    pend_nxt  = pend | load_i;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        pend_nxt = pend;
        if (load_i != 2'b00) begin
          mask_nxt  = load_i;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        cnt_nxt   = ADDR_BITS'(NBEAMS - 1);
        state_nxt = SHIFT;
      end
      SHIFT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == '0) state_nxt = UPDATE;
      end
      UPDATE: state_nxt = DONE;
      DONE: begin
        // A request arriving in this very cycle chains straight into the next pass.
        pend_nxt = '0;
        if ((pend | load_i) != 2'b00) begin
          mask_nxt  = pend | load_i;
          state_nxt = PRIME;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the table
  // read issued in PRIME/SHIFT lands on thresh_o one cycle later.
  always_comb begin
    rd_addr    = (state == PRIME) ? ADDR_BITS'(NBEAMS - 1) : cnt - 1'b1;
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == DONE);
    wr_nxt     = (state_nxt == SHIFT)  ? mask_nxt : 2'b00;
    upd_nxt    = (state_nxt == UPDATE) ? mask     : 2'b00;
    thresh_nxt = (state_nxt == SHIFT)  ? tbl[rd_addr] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      thresh_wr_o     <= '0;
      thresh_update_o <= '0;
      thresh_o        <= '0;
    end else begin
      busy_o          <= busy_nxt;
      done_o          <= done_nxt;
      thresh_wr_o     <= wr_nxt;
      thresh_update_o <= upd_nxt;
      thresh_o        <= thresh_nxt;
    end
  end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: cycle-offset reference model compared
// every cycle, plus literal checks of streamed values per test scenario.
module tb_beam_thresh_loader;
  localparam int N  = 4;
  localparam int TB = 18;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [2:0]    thr_addr_i;
  logic          thr_sel_i;
  logic [TB-1:0] thr_dat_i;
  logic          thr_we_i;
  logic [1:0]    load_i;
  logic          busy_o, done_o;
  logic [2*TB-1:0] thresh_o;
  logic [1:0]    thresh_wr_o, thresh_update_o;

  beam_thresh_loader #(.NBEAMS(N), .THRESH_BITS(TB), .DEFAULT_THRESH(18'd4000), .ADDR_BITS(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .thr_addr_i(thr_addr_i), .thr_sel_i(thr_sel_i),
    .thr_dat_i(thr_dat_i), .thr_we_i(thr_we_i), .load_i(load_i), .busy_o(busy_o),
    .done_o(done_o), .thresh_o(thresh_o), .thresh_wr_o(thresh_wr_o),
    .thresh_update_o(thresh_update_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  // Reference: a pass is a fixed timeline measured from the accepting edge
  // (d=1 prime, d=2..N+1 beams N-1..0, d=N+2 commit, d=N+3 done).
  logic [TB-1:0] m_tbl [2][N];
  bit            m_act;
  int            m_d;
  logic [1:0]    m_mask, m_pend, p;
  logic          e_busy, e_done;
  logic [1:0]    e_wr, e_upd;
  logic [2*TB-1:0] e_thr;

  initial for (int t = 0; t < 2; t++) for (int b = 0; b < N; b++) m_tbl[t][b] = 18'd4000;

  always @(posedge clk) begin
    if (rst_i) begin
      m_act = 0; m_d = 0; m_mask = 0; m_pend = 0;
    end else if (!m_act) begin
      if (load_i != 0) begin m_act = 1; m_d = 1; m_mask = load_i; end
    end else if (m_d == N + 3) begin
      p = m_pend | load_i; m_pend = 0;
      if (p != 0) begin m_d = 1; m_mask = p; end
      else m_act = 0;
    end else begin
      m_pend = m_pend | load_i; m_d++;
    end
    e_busy = m_act;
    e_done = m_act && (m_d == N + 3);
    e_wr   = (m_act && m_d >= 2 && m_d <= N + 1) ? m_mask : 2'b00;
    e_upd  = (m_act && m_d == N + 2) ? m_mask : 2'b00;
    e_thr  = (e_wr != 0) ? {m_tbl[1][N+1-m_d], m_tbl[0][N+1-m_d]} : '0;
    if (thr_we_i && int'(thr_addr_i) < N) m_tbl[thr_sel_i][thr_addr_i] = thr_dat_i;
  end

  logic [2*TB-1:0] tm;
  always @(negedge clk) if (chk_en) begin
    tm = {{TB{e_wr[1]}}, {TB{e_wr[0]}}};
    n_cmp++;
    if (busy_o !== e_busy || done_o !== e_done || thresh_wr_o !== e_wr ||
        thresh_update_o !== e_upd ||
        (e_wr != 0 ? ((thresh_o & tm) !== (e_thr & tm)) : (thresh_o !== '0))) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b wr=%b upd=%b thr=%h, required busy=%b done=%b wr=%b upd=%b thr=%h",
               $time, busy_o, done_o, thresh_wr_o, thresh_update_o, thresh_o,
               e_busy, e_done, e_wr, e_upd, e_thr);
    end
  end

  // Capture of what the DUT actually shifted into the chain.
  logic [2*TB-1:0] cap_q [$];
  logic [1:0]      capm_q [$];
  int              upd_cnt;
  always @(negedge clk) begin
    if (thresh_wr_o != 0) begin cap_q.push_back(thresh_o); capm_q.push_back(thresh_wr_o); end
    if (thresh_update_o != 0) upd_cnt++;
  end

  logic [TB-1:0] ex0 [N], ex1 [N];

  task automatic chk(input string nm, input logic [2*TB-1:0] act, input logic [2*TB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pass(input string nm, input int off, input logic [1:0] m);
    logic [2*TB-1:0] v, msk;
    logic [1:0] vm;
    msk = {{TB{m[1]}}, {TB{m[0]}}};
    for (int i = 0; i < N; i++) begin
      v  = (off + i < cap_q.size()) ? cap_q[off+i] : '1;
      vm = (off + i < capm_q.size()) ? capm_q[off+i] : 2'b00;
      chk({nm, "_mask"}, {34'd0, vm}, {34'd0, m});
      chk({nm, "_val"}, v & msk, {ex1[N-1-i], ex0[N-1-i]} & msk);
    end
  endtask

  task automatic clr();
    cap_q.delete(); capm_q.delete(); upd_cnt = 0;
  endtask

  task automatic wr(input logic sel, input logic [2:0] a, input logic [TB-1:0] d);
    thr_we_i = 1; thr_sel_i = sel; thr_addr_i = a; thr_dat_i = d;
    @(negedge clk);
    thr_we_i = 0;
  endtask

  task automatic ld(input logic [1:0] m);
    load_i = m;
    @(negedge clk);
    load_i = 2'b00;
  endtask

  initial begin
    rst_i = 1; thr_addr_i = 0; thr_sel_i = 0; thr_dat_i = 0; thr_we_i = 0; load_i = 0;
    @(negedge clk); chk_en = 1;
    chk("reset_busy", {35'd0, busy_o}, 36'd0);
    chk("reset_thresh", thresh_o, 36'd0);
    @(negedge clk); rst_i = 0;

    // Defaults stream out with no writes since power-up.
    clr(); ld(2'b01); repeat (10) @(negedge clk);
    for (int i = 0; i < N; i++) begin ex0[i] = 18'd4000; ex1[i] = 18'd4000; end
    chk("t6_len", cap_q.size(), N);
    chk_pass("t6", 0, 2'b01);
    chk("t6_upd", upd_cnt, 1);

    // Single type.
    for (int i = 0; i < N; i++) wr(0, 3'(i), 18'(100 + i));
    clr(); ld(2'b01); repeat (10) @(negedge clk);
    for (int i = 0; i < N; i++) ex0[i] = 18'(100 + i);
    chk("t1_len", cap_q.size(), N);
    chk_pass("t1", 0, 2'b01);
    chk("t1_upd", upd_cnt, 1);

    // Both types in one pass.
    for (int i = 0; i < N; i++) wr(1, 3'(i), 18'(200 + i));
    clr(); ld(2'b11); repeat (10) @(negedge clk);
    for (int i = 0; i < N; i++) ex1[i] = 18'(200 + i);
    chk("t2_len", cap_q.size(), N);
    chk_pass("t2", 0, 2'b11);
    chk("t2_upd", upd_cnt, 1);

    // Request while busy queues a second back-to-back pass.
    clr(); ld(2'b01); repeat (2) @(negedge clk); ld(2'b10); repeat (14) @(negedge clk);
    chk("t3_len", cap_q.size(), 2 * N);
    chk_pass("t3a", 0, 2'b01);
    chk_pass("t3b", N, 2'b10);
    chk("t3_upd", upd_cnt, 2);

    // Request in the DONE cycle also chains.
    clr(); ld(2'b10); repeat (6) @(negedge clk); ld(2'b01); repeat (12) @(negedge clk);
    chk("t7_len", cap_q.size(), 2 * N);
    chk_pass("t7a", 0, 2'b10);
    chk_pass("t7b", N, 2'b01);

    // Reset mid-shift aborts without a commit; table survives.
    clr(); ld(2'b01); repeat (2) @(negedge clk);
    rst_i = 1; @(negedge clk); rst_i = 0;
    repeat (8) @(negedge clk);
    chk("t4_upd", upd_cnt, 0);
    clr(); ld(2'b01); repeat (10) @(negedge clk);
    chk("t4_len", cap_q.size(), N);
    chk_pass("t4", 0, 2'b01);

    // Write to beam 0 in the cycle it is read, plus out-of-range writes.
    clr(); ld(2'b01); repeat (3) @(negedge clk);
    wr(0, 3'd0, 18'd555); wr(0, 3'd4, 18'd999); wr(1, 3'd7, 18'd777);
    repeat (6) @(negedge clk);
    chk_pass("t5a", 0, 2'b01);
    clr(); ld(2'b11); repeat (10) @(negedge clk);
    ex0[0] = 18'd555;
    chk_pass("t5b", 0, 2'b11);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
